keypad_emulator: RTL

- Drives the keypad end of the 4-column × 3-row matrix interface. It is the responder to the column-scanning keypad FSM.
- It watches the one-hot column drives B, G, F, D and asserts row lines C, A, E exactly as a physical key closure would.
- A test or host block submits one key code per request over a valid/ready handshake. The emulator holds that key for a programmed number of scans, then releases it for a programmed number of scans.
- Used for on-board self-test and simulation of the keypad decode path.

---
 rtl/keypad_emulator_if.sv | 20 ++
 rtl/keypad_emulator.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator_if.sv
// Key request handshake between a test/host block and the keypad emulator.
// The host (master) offers one key code per transfer; the emulator (slave)
// accepts it when KEY_VALID and KEY_READY are both high at a rising edge.
interface keypad_emulator_if;
  logic       KEY_VALID;
  logic [3:0] KEY_CODE;
  logic       KEY_READY;

  modport master (
    output KEY_VALID,
    output KEY_CODE,
    input  KEY_READY
  );

  modport slave (
    input  KEY_VALID,
    input  KEY_CODE,
    output KEY_READY
  );
endinterface

// File: rtl/keypad_emulator.sv
// Keypad emulator: sits on the keypad side of a 4-column x 3-row matrix and
// answers the column-scanning FSM exactly like a physical key closure.
// A requested key is held for HOLD_SCANS activations of its own column, then
// released for GAP_SCANS activations of column B before the next request.
// A request that sees no column activity for TIMEOUT cycles is abandoned.
module keypad_emulator #(
  parameter int HOLD_SCANS = 4,
  parameter int GAP_SCANS  = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic             CLK,
  input  logic             RST,
  keypad_emulator_if.slave keyIf,
  input  logic             B,
  input  logic             G,
  input  logic             F,
  input  logic             D,
  output logic             C,
  output logic             A,
  output logic             E,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Counters compare against "last value" so a hit happens on the activation
  // that brings the count up to the programmed number.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_SCANS - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_SCANS - 1);
  localparam logic [9:0] TMO_LAST  = 10'(TIMEOUT - 1);

  state_t     r_state;
  logic [3:0] r_prevCol;
  logic [3:0] r_cnt;
  logic [9:0] r_tmo;
  logic [1:0] r_keyCol;
  logic [1:0] r_keyRow;
  logic       r_done;
  logic       r_err;

  // Column bit order: 0 = B, 1 = G, 2 = F, 3 = D.
  logic [3:0] w_col;
  logic       w_legal;
  logic [3:0] w_act;
  logic       w_anyAct;
  logic       w_keyAct;
  logic       w_xfer;
  logic       w_codeOk;
  logic [1:0] w_codeCol;
  logic [1:0] w_codeRow;
  logic [2:0] w_rows;

  assign w_col    = {D, F, G, B};
  // Multi-hot column states are treated as glitches: no activations, no rows.
  assign w_legal  = ((w_col & (w_col - 4'd1)) == 4'd0);
  assign w_act    = w_legal ? (w_col & ~r_prevCol) : 4'd0;
  assign w_anyAct = |w_act;
  assign w_keyAct = w_act[r_keyCol];

  assign keyIf.KEY_READY = (r_state == IDLE) && !RST;
  assign w_xfer          = keyIf.KEY_VALID && keyIf.KEY_READY;

  assign BUSY = (r_state != IDLE);
  assign DONE = r_done && !RST;
  assign ERR  = r_err && !RST;
  assign C    = w_rows[0];
  assign A    = w_rows[1];
  assign E    = w_rows[2];

  // Translate the offered key code into its (column, row) position on the matrix.
  always_comb begin
    w_codeOk  = 1'b1;
    w_codeCol = 2'd0;
    w_codeRow = 2'd0;
    case (keyIf.KEY_CODE)
      4'd1:    {w_codeCol, w_codeRow} = {2'd0, 2'd0};
      4'd2:    {w_codeCol, w_codeRow} = {2'd0, 2'd1};
      4'd3:    {w_codeCol, w_codeRow} = {2'd0, 2'd2};
      4'd4:    {w_codeCol, w_codeRow} = {2'd1, 2'd0};
      4'd5:    {w_codeCol, w_codeRow} = {2'd1, 2'd1};
      4'd6:    {w_codeCol, w_codeRow} = {2'd1, 2'd2};
      4'd7:    {w_codeCol, w_codeRow} = {2'd2, 2'd0};
      4'd8:    {w_codeCol, w_codeRow} = {2'd2, 2'd1};
      4'd9:    {w_codeCol, w_codeRow} = {2'd2, 2'd2};
      4'd10:   {w_codeCol, w_codeRow} = {2'd3, 2'd0};
      4'd0:    {w_codeCol, w_codeRow} = {2'd3, 2'd1};
      4'd11:   {w_codeCol, w_codeRow} = {2'd3, 2'd2};
      default: w_codeOk = 1'b0;
    endcase
  end

  // Rows follow the live column level so the scanner sees the closure in the same cycle it drives the column.
  always_comb begin
    w_rows = 3'b000;
    if (!RST && (r_state == PRESS) && w_legal && w_col[r_keyCol]) begin
      case (r_keyRow)
        2'd0:    w_rows = 3'b001;
        2'd1:    w_rows = 3'b010;
        default: w_rows = 3'b100;
      endcase
    end
  end

  // Request FSM: accept a key, count hold scans, count release scans, watch for a stalled scanner.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_prevCol <= 4'd0;
      r_cnt     <= 4'd0;
      r_tmo     <= 10'd0;
      r_keyCol  <= 2'd0;
      r_keyRow  <= 2'd0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_prevCol <= w_col;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            if (w_codeOk) begin
              r_keyCol <= w_codeCol;
              r_keyRow <= w_codeRow;
              r_cnt    <= 4'd0;
              r_tmo    <= 10'd0;
              r_state  <= PRESS;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        PRESS: begin
          if (w_anyAct) begin
            r_tmo <= 10'd0;
            if (w_keyAct) begin
              if (r_cnt == HOLD_LAST) begin
                r_cnt   <= 4'd0;
                r_state <= RELEASE;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
          end else if (r_tmo == TMO_LAST) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 10'd1;
          end
        end
        RELEASE: begin
          if (w_anyAct) begin
            r_tmo <= 10'd0;
            if (w_act[0]) begin
              if (r_cnt == GAP_LAST) begin
                r_cnt   <= 4'd0;
                r_state <= IDLE;
                r_done  <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
          end else if (r_tmo == TMO_LAST) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 10'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
